// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : multi-cycle adder, CHUNK bits per cycle, LSB chunk first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy
);

    localparam int STEPS   = WIDTH / CHUNK;
    localparam int c_CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(STEPS - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("serial_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_p;
    logic               r_c;
    logic [c_CNT_W-1:0] r_cnt;

    logic [CHUNK:0]     w_chunk;
    logic [WIDTH-1:0]   w_p_next;

    assign w_chunk = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, r_c};

    // New chunk enters at the MSB end; after STEPS shifts the LSB chunk lands at bit 0.
    assign w_p_next = WIDTH'({w_chunk[CHUNK-1:0], r_p} >> CHUNK);

    assign in_ready = (r_state == S_IDLE) && !rst;
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_p       <= '0;
            r_c       <= 1'b0;
            r_cnt     <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= carry_in;
                        r_cnt   <= '0;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_a   <= r_a >> CHUNK;
                    r_b   <= r_b >> CHUNK;
                    r_c   <= w_chunk[CHUNK];
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        sum       <= w_p_next;
                        carry     <= w_chunk[CHUNK];
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : directed self-checking bench for serial_adder (8/1, 16/4, 16/16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // WIDTH=8, CHUNK=1 instance
    logic       iv8 = 1'b0, or8 = 1'b0, ci8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ir8, ov8, c8, bz8;
    logic [7:0] s8;

    // Two WIDTH=16 instances share operand inputs
    logic        iv16a = 1'b0, iv16b = 1'b0, or16 = 1'b0, ci16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ir16a, ov16a, c16a, bz16a;
    logic        ir16b, ov16b, c16b, bz16b;
    logic [15:0] s16a, s16b;

    serial_adder #(.WIDTH(8), .CHUNK(1)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .carry_in(ci8), .out_valid(ov8), .out_ready(or8),
        .sum(s8), .carry(c8), .busy(bz8)
    );

    serial_adder #(.WIDTH(16), .CHUNK(4)) u_d16a (
        .clk(clk), .rst(rst), .in_valid(iv16a), .in_ready(ir16a),
        .a(a16), .b(b16), .carry_in(ci16), .out_valid(ov16a), .out_ready(or16),
        .sum(s16a), .carry(c16a), .busy(bz16a)
    );

    serial_adder #(.WIDTH(16), .CHUNK(16)) u_d16b (
        .clk(clk), .rst(rst), .in_valid(iv16b), .in_ready(ir16b),
        .a(a16), .b(b16), .carry_in(ci16), .out_valid(ov16b), .out_ready(or16),
        .sum(s16b), .carry(c16b), .busy(bz16b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input int hold,
                        input string tag);
        int   lat;
        logic bbad;
        lat  = 0;
        bbad = 1'b0;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 32'(ir8), 32'd1);
        a8 = ta; b8 = tb; ci8 = tc; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        a8 = ~ta; b8 = ~tb; ci8 = ~tc;
        if (!bz8 || ov8) bbad = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!bz8) bbad = 1'b1;
            if (ov8) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd8);
        check_eq({tag, "_sum"},     32'(s8),  32'(es));
        check_eq({tag, "_carry"},   32'(c8),  32'(ec));
        for (int h = 0; h < hold; h++) begin
            iv8 = ~iv8;
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 32'(ov8), 32'd1);
            check_eq({tag, "_hold_sum"},   32'(s8),  32'(es));
            check_eq({tag, "_hold_carry"}, 32'(c8),  32'(ec));
            check_eq({tag, "_hold_ready"}, 32'(ir8), 32'd0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        if (bz8) bbad = 1'b1;
        check_eq({tag, "_post_valid"}, 32'(ov8),  32'd0);
        check_eq({tag, "_post_ready"}, 32'(ir8),  32'd1);
        check_eq({tag, "_busy"},       32'(bbad), 32'd0);
    endtask

    task automatic add16(input bit sel, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic [15:0] es, input logic ec,
                         input int elat, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 32'(sel ? ir16b : ir16a), 32'd1);
        a16 = ta; b16 = tb; ci16 = tc;
        if (sel) iv16b = 1'b1; else iv16a = 1'b1;
        @(negedge clk);
        iv16a = 1'b0; iv16b = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sel ? ov16b : ov16a) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(elat));
        check_eq({tag, "_sum"},   32'(sel ? s16b : s16a), 32'(es));
        check_eq({tag, "_carry"}, 32'(sel ? c16b : c16a), 32'(ec));
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        check_eq({tag, "_post_valid"}, 32'(sel ? ov16b : ov16a), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 32'(ir8), 32'd0);
        check_eq("rst_valid",    32'(ov8), 32'd0);
        check_eq("rst_busy",     32'(bz8), 32'd0);
        check_eq("rst_sum",      32'(s8),  32'd0);
        rst = 1'b0;

        add8(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 0, "basic");

        // Asynchronous reset between clock edges clears the held result.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_sum",      32'(s8),  32'd0);
        check_eq("async_carry",    32'(c8),  32'd0);
        check_eq("async_valid",    32'(ov8), 32'd0);
        check_eq("async_busy",     32'(bz8), 32'd0);
        check_eq("async_in_ready", 32'(ir8), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, "wrap1");
        add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, "wrap2");
        add8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 0, "cin_only");
        add8(8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 5, "backpressure");
        add8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0, "after_bp");

        // Abort during the third ADD step.
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_sum",   32'(s8),  32'd0);
        check_eq("abort_valid", 32'(ov8), 32'd0);
        check_eq("abort_busy",  32'(bz8), 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (ov8) seen = 1'b1;
            end
            rst = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (ov8) seen = 1'b1;
            end
            check_eq("abort_no_valid", 32'(seen), 32'd0);
            check_eq("abort_carry",    32'(c8),   32'd0);
        end
        add8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0, "post_abort");

        add16(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4, "w16c4");
        add16(1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1, "w16c16");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
